refill_controller: RTL and testbench

Miss-refill engine between the direct-mapped data cache and main data memory.
- Accepts a single-word refill request from the cache on a miss.
- Issues a one-cycle read strobe to the synchronous main memory and waits a fixed latency.
- Returns the word to the cache with a one-cycle valid pulse, and stalls the pipeline for the whole miss.

---
 rtl/refill_pkg.sv | 23 ++
 rtl/refill_latency_counter.sv | 40 ++++
 rtl/refill_controller.sv | 175 +++++++++++++++++
 tb/tb_refill_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/refill_pkg.sv
// Shared types and helpers for the data-cache miss refill engine.
package refill_pkg;

  // Refill FSM states, encoded explicitly so the state register layout is fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } refill_state_t;

  // Byte offset bits inside a memory word.
  localparam int WORD_OFFSET = 2;

  // Widest address the alignment helper handles; callers cast to their width.
  localparam int ADDR_MAX_WIDTH = 64;

  // Clear the byte-offset bits so the address points at the start of a word.
  function automatic logic [ADDR_MAX_WIDTH-1:0] word_align(input logic [ADDR_MAX_WIDTH-1:0] addr);
    return addr & ~((64'd1 << WORD_OFFSET) - 64'd1);
  endfunction

endpackage

// File: rtl/refill_latency_counter.sv
// Loadable down-counter that times the main-memory read latency.
// zero_o is combinational so the FSM can act on the last wait cycle.
module refill_latency_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins over decrement, decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/refill_controller.sv
// Single-word miss refill engine between the direct-mapped data cache and
// main memory: IDLE -> REQ (read strobe) -> WAIT (MEM_LATENCY cycles) -> RESP.
// Optional performance counters are built only when REFILL_PERF_EN is defined;
// otherwise oMissCount/oStallCycles are tied to zero.
module refill_controller
  import refill_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iMissReq,
  input  logic [ADDR_WIDTH-1:0] iMissAddress,
  output logic                  oStall,
  output logic                  oMemReadEn,
  output logic [ADDR_WIDTH-1:0] oMemAddress,
  input  logic [DATA_WIDTH-1:0] iMemData,
  output logic                  oRefillValid,
  output logic [ADDR_WIDTH-1:0] oRefillAddress,
  output logic [DATA_WIDTH-1:0] oRefillData,
  output logic [CNT_WIDTH-1:0]  oMissCount,
  output logic [CNT_WIDTH-1:0]  oStallCycles
);

  localparam int LAT_CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

  // A zero latency would leave no cycle to capture memory data.
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("refill_controller: MEM_LATENCY must be at least 1");
  end

  refill_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mem_read_en_q, mem_read_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  refill_valid_q, refill_valid_d;
  logic [ADDR_WIDTH-1:0] refill_addr_q, refill_addr_d;
  logic [DATA_WIDTH-1:0] refill_data_q, refill_data_d;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic [ADDR_WIDTH-1:0] miss_addr_aligned;

  assign miss_addr_aligned = ADDR_WIDTH'(word_align(ADDR_MAX_WIDTH'(iMissAddress)));

  refill_latency_counter #(
    .CNT_W (LAT_CNT_W)
  ) u_lat_cnt (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // FSM next state; outputs are computed one cycle early so they are registered in their state.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    mem_read_en_d  = 1'b0;
    mem_addr_d     = mem_addr_q;
    refill_valid_d = 1'b0;
    refill_addr_d  = refill_addr_q;
    refill_data_d  = refill_data_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    case (state_q)
      IDLE: begin
        if (iMissReq) begin
          addr_d        = miss_addr_aligned;
          mem_read_en_d = 1'b1;
          mem_addr_d    = miss_addr_aligned;
          state_d       = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        cnt_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
          state_d = WAIT;
        end else begin
          refill_data_d  = iMemData;
          refill_addr_d  = addr_q;
          refill_valid_d = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any refill in flight.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q        <= IDLE;
      addr_q         <= {ADDR_WIDTH{1'b0}};
      mem_read_en_q  <= 1'b0;
      mem_addr_q     <= {ADDR_WIDTH{1'b0}};
      refill_valid_q <= 1'b0;
      refill_addr_q  <= {ADDR_WIDTH{1'b0}};
      refill_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_addr_q     <= mem_addr_d;
      refill_valid_q <= refill_valid_d;
      refill_addr_q  <= refill_addr_d;
      refill_data_q  <= refill_data_d;
    end
  end

  // Stall is combinational so the pipeline freezes in the same cycle the miss appears.
  assign oStall = (state_q != IDLE) || ((state_q == IDLE) && iMissReq);

  assign oMemReadEn     = mem_read_en_q;
  assign oMemAddress    = mem_addr_q;
  assign oRefillValid   = refill_valid_q;
  assign oRefillAddress = refill_addr_q;
  assign oRefillData    = refill_data_q;

`ifdef REFILL_PERF_EN
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  // Counter increments: one per completed refill, one per stalled cycle; both wrap.
  always_comb begin
    miss_count_d   = miss_count_q;
    stall_cycles_d = stall_cycles_q;
    if (state_q == RESP) begin
      miss_count_d = miss_count_q + CNT_WIDTH'(1);
    end else begin
      miss_count_d = miss_count_q;
    end
    if (oStall) begin
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      miss_count_q   <= {CNT_WIDTH{1'b0}};
      stall_cycles_q <= {CNT_WIDTH{1'b0}};
    end else begin
      miss_count_q   <= miss_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign oMissCount   = miss_count_q;
  assign oStallCycles = stall_cycles_q;
`else
  assign oMissCount   = {CNT_WIDTH{1'b0}};
  assign oStallCycles = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_refill_controller.sv
// Directed bench for refill_controller (MEM_LATENCY=3): a per-cycle vector
// table plus hand-written sequences for back-to-back misses, reset in WAIT
// and the optional performance counters (REFILL_PERF_EN).
module tb_refill_controller;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iMissReq = 1'b0;
  logic [31:0] iMissAddress = 32'h0;
  logic [31:0] iMemData = 32'h0;
  logic        oStall;
  logic        oMemReadEn;
  logic [31:0] oMemAddress;
  logic        oRefillValid;
  logic [31:0] oRefillAddress;
  logic [31:0] oRefillData;
  logic [31:0] oMissCount;
  logic [31:0] oStallCycles;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] G = 32'h1111_1111;  // filler memory data outside the capture cycle

  refill_controller dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iMissReq       (iMissReq),
    .iMissAddress   (iMissAddress),
    .oStall         (oStall),
    .oMemReadEn     (oMemReadEn),
    .oMemAddress    (oMemAddress),
    .iMemData       (iMemData),
    .oRefillValid   (oRefillValid),
    .oRefillAddress (oRefillAddress),
    .oRefillData    (oRefillData),
    .oMissCount     (oMissCount),
    .oStallCycles   (oStallCycles)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] mdata;
    logic        stall;
    logic        rd;
    logic [31:0] maddr;
    logic        valid;
    logic [31:0] raddr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic req, input logic [31:0] addr, input logic [31:0] mdata,
                         input logic stall, input logic rd, input logic [31:0] maddr,
                         input logic valid, input logic [31:0] raddr, input logic [31:0] rdata);
    vecs[i].req = req;     vecs[i].addr = addr;   vecs[i].mdata = mdata;
    vecs[i].stall = stall; vecs[i].rd = rd;       vecs[i].maddr = maddr;
    vecs[i].valid = valid; vecs[i].raddr = raddr; vecs[i].rdata = rdata;
  endtask

  // Drive one cycle's inputs just after the rising edge; outputs are sampled at the falling edge.
  task automatic drive(input logic rst, input logic req, input logic [31:0] addr, input logic [31:0] mdata);
    @(posedge iCLK);
    #1;
    iRST = rst;
    iMissReq = req;
    iMissAddress = addr;
    iMemData = mdata;
    @(negedge iCLK);
  endtask

  int pulses, rd_cnt, first_valid_cyc, second_rd_cyc, n_valid;
  logic [31:0] second_rd_addr;
  bit seen;

  initial begin
    // Single aligned miss at 0x1044, data 0xDEADBEEF in the last WAIT cycle
    set_vec(0,  1'b1, 32'h1044, G,            1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    32'h0);
    set_vec(1,  1'b1, 32'h1044, G,            1'b1, 1'b1, 32'h1044, 1'b0, 32'h0,    32'h0);
    set_vec(2,  1'b1, 32'h1044, G,            1'b1, 1'b0, 32'h1044, 1'b0, 32'h0,    32'h0);
    set_vec(3,  1'b1, 32'h1044, G,            1'b1, 1'b0, 32'h1044, 1'b0, 32'h0,    32'h0);
    set_vec(4,  1'b1, 32'h1044, 32'hDEADBEEF, 1'b1, 1'b0, 32'h1044, 1'b0, 32'h0,    32'h0);
    set_vec(5,  1'b1, 32'h1044, G,            1'b1, 1'b0, 32'h1044, 1'b1, 32'h1044, 32'hDEADBEEF);
    set_vec(6,  1'b0, 32'h1044, G,            1'b0, 1'b0, 32'h1044, 1'b0, 32'h1044, 32'hDEADBEEF);
    // Unaligned miss at 0x2007 -> word 0x2004
    set_vec(7,  1'b1, 32'h2007, G,            1'b1, 1'b0, 32'h1044, 1'b0, 32'h1044, 32'hDEADBEEF);
    set_vec(8,  1'b1, 32'h2007, G,            1'b1, 1'b1, 32'h2004, 1'b0, 32'h1044, 32'hDEADBEEF);
    set_vec(9,  1'b1, 32'h2007, G,            1'b1, 1'b0, 32'h2004, 1'b0, 32'h1044, 32'hDEADBEEF);
    set_vec(10, 1'b1, 32'h2007, G,            1'b1, 1'b0, 32'h2004, 1'b0, 32'h1044, 32'hDEADBEEF);
    set_vec(11, 1'b1, 32'h2007, 32'hCAFEF00D, 1'b1, 1'b0, 32'h2004, 1'b0, 32'h1044, 32'hDEADBEEF);
    set_vec(12, 1'b1, 32'h2007, G,            1'b1, 1'b0, 32'h2004, 1'b1, 32'h2004, 32'hCAFEF00D);
    set_vec(13, 1'b0, 32'h2007, G,            1'b0, 1'b0, 32'h2004, 1'b0, 32'h2004, 32'hCAFEF00D);
    // Address changes 0x100 -> 0x200 during WAIT; 0x100 completes, 0x200 never issued
    set_vec(14, 1'b1, 32'h100,  G,            1'b1, 1'b0, 32'h2004, 1'b0, 32'h2004, 32'hCAFEF00D);
    set_vec(15, 1'b1, 32'h100,  G,            1'b1, 1'b1, 32'h100,  1'b0, 32'h2004, 32'hCAFEF00D);
    set_vec(16, 1'b1, 32'h200,  G,            1'b1, 1'b0, 32'h100,  1'b0, 32'h2004, 32'hCAFEF00D);
    set_vec(17, 1'b1, 32'h200,  G,            1'b1, 1'b0, 32'h100,  1'b0, 32'h2004, 32'hCAFEF00D);
    set_vec(18, 1'b1, 32'h200,  32'h0BADF00D, 1'b1, 1'b0, 32'h100,  1'b0, 32'h2004, 32'hCAFEF00D);
    set_vec(19, 1'b1, 32'h200,  G,            1'b1, 1'b0, 32'h100,  1'b1, 32'h100,  32'h0BADF00D);
    set_vec(20, 1'b0, 32'h200,  G,            1'b0, 1'b0, 32'h100,  1'b0, 32'h100,  32'h0BADF00D);
    set_vec(21, 1'b0, 32'h200,  G,            1'b0, 1'b0, 32'h100,  1'b0, 32'h100,  32'h0BADF00D);

    // Reset state
    drive(1'b1, 1'b0, 32'h0, G);
    drive(1'b1, 1'b0, 32'h0, G);
    check("reset_outputs",
          {93'd0, oStall, oMemReadEn, oMemAddress, oRefillValid, oRefillAddress, oRefillData},
          192'd0);
    check("reset_counters", {128'd0, oMissCount, oStallCycles}, 192'd0);

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      drive(1'b0, vecs[i].req, vecs[i].addr, vecs[i].mdata);
      check($sformatf("vec%0d", i),
            {93'd0, oStall, oMemReadEn, oMemAddress, oRefillValid, oRefillAddress, oRefillData},
            {93'd0, vecs[i].stall, vecs[i].rd, vecs[i].maddr, vecs[i].valid, vecs[i].raddr, vecs[i].rdata});
    end

    // Back-to-back: request held one cycle past the first pulse with address 0x80
    pulses = 0; rd_cnt = 0; first_valid_cyc = -100; second_rd_cyc = -1; second_rd_addr = 32'h0;
    for (int c = 0; c < 30; c++) begin
      drive(1'b0, (pulses < 2), (pulses == 0) ? 32'h40 : 32'h80, G);
      if (oMemReadEn) begin
        rd_cnt++;
        if (rd_cnt == 2) begin
          second_rd_cyc = c;
          second_rd_addr = oMemAddress;
        end
      end
      if (oRefillValid) begin
        pulses++;
        if (pulses == 1) first_valid_cyc = c;
      end
    end
    check("b2b_req_gap", 192'(second_rd_cyc - first_valid_cyc), 192'd2);
    check("b2b_second_addr", 192'(second_rd_addr), 192'h80);
    check("b2b_pulses", 192'(pulses), 192'd2);
    check("b2b_strobes", 192'(rd_cnt), 192'd2);

    // Reset asserted in the second WAIT cycle
    drive(1'b0, 1'b1, 32'h300, G);   // IDLE with request
    drive(1'b0, 1'b1, 32'h300, G);   // REQ
    drive(1'b0, 1'b1, 32'h300, G);   // WAIT 1
    drive(1'b1, 1'b0, 32'h300, G);   // WAIT 2 with reset
    drive(1'b0, 1'b0, 32'h300, 32'h5555_AAAA);
    check("rst_mid_wait",
          {93'd0, oStall, oMemReadEn, oMemAddress, oRefillValid, oRefillAddress, oRefillData},
          192'd0);
    n_valid = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 32'h300, 32'h5555_AAAA);
      if (oRefillValid || oMemReadEn || oStall) n_valid++;
    end
    check("rst_mid_no_activity", 192'(n_valid), 192'd0);

    // Performance counters over three isolated misses
    drive(1'b1, 1'b0, 32'h0, G);
    for (int m = 0; m < 3; m++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        drive(1'b0, 1'b1, 32'h400 + 32'(m * 4), G);
        if (oRefillValid) seen = 1'b1;
      end
      check($sformatf("perf_miss%0d_done", m), 192'(seen), 192'd1);
      drive(1'b0, 1'b0, 32'h0, G);
      drive(1'b0, 1'b0, 32'h0, G);
    end
`ifdef REFILL_PERF_EN
    check("perf_miss_count", 192'(oMissCount), 192'd3);
    check("perf_stall_cycles", 192'(oStallCycles), 192'd18);
`else
    check("perf_miss_count_tied", 192'(oMissCount), 192'd0);
    check("perf_stall_cycles_tied", 192'(oStallCycles), 192'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
